// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcode values, ALU
// function codes, B-mux codes, FSM state encoding and the opcode classifier.
// No ports; imported by multicycle_control_unit.
package cu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b0010;
    localparam logic [3:0] OP_CLR   = 4'b0110;
    localparam logic [3:0] OP_RST   = 4'b0111;
    localparam logic [3:0] OP_NOP   = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1001;
    localparam logic [3:0] OP_BEQZ  = 4'b1010;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_STORE = 4'b1100;

    localparam logic [3:0] G_PASS_A = 4'b0000;
    localparam logic [3:0] G_ADD    = 4'b0010;
    localparam logic [3:0] G_SUB    = 4'b0101;

    localparam logic [1:0] MB_REG   = 2'd0;
    localparam logic [1:0] MB_CONST = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } cu_state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_ADDI, K_CLR, K_RST, K_NOP,
        K_JMP, K_BEQZ, K_LOAD, K_STORE, K_ILLEGAL
    } op_kind_t;

    function automatic op_kind_t classify_op(input logic [3:0] op);
        op_kind_t k;
        case (op)
            OP_ADD:   k = K_ADD;
            OP_SUB:   k = K_SUB;
            OP_ADDI:  k = K_ADDI;
            OP_CLR:   k = K_CLR;
            OP_RST:   k = K_RST;
            OP_NOP:   k = K_NOP;
            OP_JMP:   k = K_JMP;
            OP_BEQZ:  k = K_BEQZ;
            OP_LOAD:  k = K_LOAD;
            OP_STORE: k = K_STORE;
            default:  k = K_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles for the memory timeout. Down-counter loaded with
// MEM_TIMEOUT-1 on entry to MEM; expired is raised in the MEM cycle where the
// count has reached zero, i.e. the MEM_TIMEOUT-th cycle.
// Ports:
//   clk, reset_global  clock / synchronous active-high reset
//   clear              return count to zero (leaving MEM)
//   load               arm the counter (entering MEM)
//   enable             currently in MEM; decrements and qualifies expired
//   expired            terminal count reached while enabled
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_global,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LOAD_INT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_INT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset_global || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // MEM_TIMEOUT of 0 means wait forever, so the timer never expires.
    assign expired = (MEM_TIMEOUT != 0) && enable && (cnt == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: accepts an instruction from fetch over a
// valid/ready handshake, then sequences decode, execute, memory and writeback
// control for the register file, ALU, muxes and PC.
// Ports:
//   clk, reset_global             clock / synchronous active-high reset
//   instr_valid, instr_ready      fetch handshake (ready only in IDLE)
//   instruction                   {op, rA, rB}
//   zero_flag                     ALU zero flag for BEQZ
//   mem_ready                     memory completes this cycle
//   reg_a_select, reg_b_select    register read ports
//   write_enable                  one-hot register write strobe
//   g_select                      ALU function
//   mem_read, mem_write           memory strobes
//   mb_select, mf_select, md_select  datapath mux selects
//   load, set_value               PC load strobe and target
//   constant_in                   zero-extended immediate
//   reset_individual, reset_all   register clear strobes
//   busy                          not in IDLE
//   illegal_op, mem_timeout       one-cycle error pulses
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// DECODE | ir classified; illegal opcodes flagged here
// EXEC   | single-cycle ALU / clear / jump / branch
// MEM    | LOAD/STORE strobes held until mem_ready or timeout
// WB     | memory data written to rA
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int REG_ADDR_W  = 3,
    parameter  int OPCODE_W    = 4,
    parameter  int PC_W        = 8,
    parameter  int MEM_TIMEOUT = 16,
    localparam int NUM_REGS    = 1 << REG_ADDR_W,
    localparam int INSTR_W     = OPCODE_W + 2 * REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_global,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  zero_flag,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] reg_a_select,
    output logic [REG_ADDR_W-1:0] reg_b_select,
    output logic [NUM_REGS-1:0]   write_enable,
    output logic [3:0]            g_select,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mb_select,
    output logic                  mf_select,
    output logic                  md_select,
    output logic                  load,
    output logic [PC_W-1:0]       set_value,
    output logic [DATA_W-1:0]     constant_in,
    output logic                  reset_individual,
    output logic                  reset_all,
    output logic                  busy,
    output logic                  illegal_op,
    output logic                  mem_timeout
);

    cu_state_t              state, state_next;
    logic [INSTR_W-1:0]     ir;
    logic [OPCODE_W-1:0]    ir_op;
    logic [REG_ADDR_W-1:0]  ir_ra, ir_rb;
    logic [NUM_REGS-1:0]    we_ra;
    op_kind_t               kind;
    logic                   accept;
    logic                   tmr_load, tmr_clear, tmr_en, tmr_expired;

    assign ir_op = ir[INSTR_W-1 -: OPCODE_W];
    assign ir_ra = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ir_rb = ir[REG_ADDR_W-1:0];
    assign we_ra = NUM_REGS'(1) << ir_ra;

    // Opcodes are 4-bit codes; with a wider opcode field the extra MSBs must be zero.
    always_comb begin
        kind = K_ILLEGAL;
        if ((ir_op >> 4) == '0) begin
            kind = classify_op(4'(ir_op));
        end
    end

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset_global) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ir <= instruction;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (instr_valid) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (kind)
                    K_LOAD, K_STORE:     state_next = ST_MEM;
                    K_NOP, K_ILLEGAL:    state_next = ST_IDLE;
                    default:             state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: state_next = ST_IDLE;
            ST_MEM: begin
                // mem_ready beats a simultaneous timeout.
                if (mem_ready) begin
                    state_next = (kind == K_LOAD) ? ST_WB : ST_IDLE;
                end else if (tmr_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign tmr_en    = (state == ST_MEM);
    assign tmr_load  = (state == ST_DECODE) && (state_next == ST_MEM);
    assign tmr_clear = tmr_en && (state_next != ST_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk          (clk),
        .reset_global (reset_global),
        .clear        (tmr_clear),
        .load         (tmr_load),
        .enable       (tmr_en),
        .expired      (tmr_expired)
    );

    always_comb begin
        reg_a_select     = '0;
        reg_b_select     = '0;
        write_enable     = '0;
        g_select         = G_PASS_A;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mb_select        = MB_REG;
        mf_select        = 1'b0;
        md_select        = 1'b0;
        load             = 1'b0;
        set_value        = '0;
        constant_in      = '0;
        reset_individual = 1'b0;
        reset_all        = 1'b0;
        illegal_op       = 1'b0;
        mem_timeout      = 1'b0;
        case (state)
            ST_DECODE: begin
                // BEQZ presents rA to the ALU early so zero_flag is settled by EXEC.
                if (kind == K_BEQZ) begin
                    reg_a_select = ir_ra;
                    g_select     = G_PASS_A;
                end
                illegal_op = (kind == K_ILLEGAL);
            end
            ST_EXEC: begin
                case (kind)
                    K_ADD, K_SUB: begin
                        reg_a_select = ir_ra;
                        reg_b_select = ir_rb;
                        g_select     = (kind == K_ADD) ? G_ADD : G_SUB;
                        write_enable = we_ra;
                    end
                    K_ADDI: begin
                        // rA is the ALU A operand: ADDI is rA <= rA + zext(rB field).
                        reg_a_select = ir_ra;
                        mb_select    = MB_CONST;
                        constant_in  = DATA_W'(ir_rb);
                        g_select     = G_ADD;
                        write_enable = we_ra;
                    end
                    K_CLR: begin
                        reset_individual = 1'b1;
                        write_enable     = we_ra;
                    end
                    K_RST: reset_all = 1'b1;
                    K_JMP: begin
                        load      = 1'b1;
                        set_value = PC_W'({ir_ra, ir_rb});
                    end
                    K_BEQZ: begin
                        reg_a_select = ir_ra;
                        g_select     = G_PASS_A;
                        load         = zero_flag;
                        set_value    = PC_W'(ir_rb);
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_read     = (kind == K_LOAD);
                mem_write    = (kind == K_STORE);
                reg_a_select = ir_ra;
                reg_b_select = ir_rb;
                mem_timeout  = tmr_expired && !mem_ready;
            end
            ST_WB: begin
                md_select    = 1'b1;
                write_enable = we_ra;
            end
            default: ;
        endcase
    end

endmodule
